// File: rtl/risc_pkg.sv
// Shared types and constants for the instruction-fetch slice.
package risc_pkg;
    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 30;
    localparam logic [INSTR_W-1:0] INSTR_ZERO = 32'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;
endpackage

// File: rtl/risc_fetch_fifo.sv
// Fetch buffer of {pc, instr} entries with a registered head.
// Flush outranks push and pop.
module risc_fetch_fifo
    import risc_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           wr_data,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign empty     = (r_count == '0);
    assign full      = (r_count == FULL_CNT);
    assign w_pop_ok  = pop && !empty;
    // A full buffer still accepts a write when the head leaves in the same cycle.
    assign w_push_ok = push && (!full || w_pop_ok);
    assign head      = r_mem[r_rd_ptr];
    assign count     = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push_ok && w_pop_ok) begin
                r_count <= r_count - 1'b1;
            end
        end
    end
endmodule

// File: rtl/risc_fetch_unit.sv
// Instruction-fetch sequencer: PC register, fetch/halt FSM and redirect handling.
// Fetched {pc, instr} pairs are buffered in risc_fetch_fifo for decode.
module risc_fetch_unit
    import risc_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FIFO_DEPTH   = 2,
    parameter bit          HALT_ON_ZERO = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        fetch_en,
    output logic [ADDR_W-1:0]           imem_addr,
    input  logic [INSTR_W-1:0]          imem_data,
    output logic                        dec_valid,
    input  logic                        dec_ready,
    output logic [INSTR_W-1:0]          dec_instr,
    output logic [31:0]                 dec_pc,
    input  logic                        redirect_valid,
    input  logic [31:0]                 redirect_pc,
    output logic                        halted,
    output logic                        misalign,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic         r_halted;
    logic         r_misalign;

    fetch_entry_t w_head;
    fetch_entry_t w_wr_data;
    logic         w_full;
    logic         w_empty;
    logic         w_pop;
    logic         w_slot;
    logic         w_zero;
    logic         w_push;

    assign w_pop     = dec_valid && dec_ready;
    assign w_slot    = fetch_en && (r_state == FETCH) && (!w_full || w_pop);
    assign w_zero    = HALT_ON_ZERO && (imem_data == INSTR_ZERO);
    assign w_push    = w_slot && !w_zero && !redirect_valid;
    assign w_wr_data = '{pc: r_pc, instr: imem_data};

    risc_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (w_push),
        .pop     (w_pop),
        .flush   (redirect_valid),
        .wr_data (w_wr_data),
        .head    (w_head),
        .count   (fifo_count),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FETCH;
            r_pc       <= RESET_PC;
            r_halted   <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= redirect_valid && (|redirect_pc[1:0]);
            if (redirect_valid) begin
                r_state  <= FETCH;
                r_pc     <= {redirect_pc[31:2], 2'b00};
                r_halted <= 1'b0;
            end else if (w_slot && w_zero) begin
                // The zero word is dropped and the PC stays on it.
                r_state  <= HALTED;
                r_halted <= 1'b1;
            end else if (w_push) begin
                r_pc <= r_pc + 32'd4;
            end
        end
    end

    assign imem_addr = r_pc[31:2];
    assign dec_valid = !w_empty;
    assign dec_instr = w_head.instr;
    assign dec_pc    = w_head.pc;
    assign halted    = r_halted;
    assign misalign  = r_misalign;
endmodule

// File: tb/tb_risc_fetch_unit.sv
// Self-checking bench for risc_fetch_unit: vector table, directed corner sequences
// and a randomized run against a queue-based reference model.
module tb_risc_fetch_unit;
    import risc_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        fetch_en;
    logic        dec_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [29:0] imem_addr;
    logic [31:0] imem_data;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        halted;
    logic        misalign;
    logic [1:0]  fifo_count;

    logic        w_fe   = 1'b1;
    logic        w_rdy  = 1'b1;
    logic        w_rv   = 1'b0;
    logic [31:0] w_rpc  = 32'h0;
    logic [31:0] w_data = 32'h0000_0013;
    logic [29:0] w_addr;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic        w_halted;
    logic        w_mis;
    logic [1:0]  w_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] prog [6] = '{32'h00800093, 32'h00108133, 32'h001081B3,
                              32'h04000213, 32'h08000293, 32'h0020A223};

    function automatic logic [31:0] imem_word(input logic [29:0] a);
        if (a < 30'd6) return prog[a[2:0]];
        return 32'h0;
    endfunction

    assign imem_data = imem_word(imem_addr);

    risc_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2), .HALT_ON_ZERO(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_addr(imem_addr),
        .imem_data(imem_data), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_instr(dec_instr), .dec_pc(dec_pc), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halted(halted), .misalign(misalign),
        .fifo_count(fifo_count)
    );

    risc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2), .HALT_ON_ZERO(1'b1)) u_wrap (
        .clk(clk), .rst_n(rst_n), .fetch_en(w_fe), .imem_addr(w_addr),
        .imem_data(w_data), .dec_valid(w_valid), .dec_ready(w_rdy),
        .dec_instr(w_instr), .dec_pc(w_pc), .redirect_valid(w_rv),
        .redirect_pc(w_rpc), .halted(w_halted), .misalign(w_mis),
        .fifo_count(w_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%08h required=%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        dec_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    typedef struct {
        logic        fe;
        logic        rdy;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic        exp_halted;
        logic [29:0] exp_addr;
    } vec_t;

    vec_t         tbl [8];
    logic [31:0]  wrap_exp [3];

    fetch_entry_t m_q[$];
    logic [31:0]  m_pc;
    logic         m_halted;
    logic         m_mis;

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b1, 32'h00, 32'h00800093, 1'b0, 30'd1};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h04, 32'h00108133, 1'b0, 30'd2};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h08, 32'h001081B3, 1'b0, 30'd3};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h0C, 32'h04000213, 1'b0, 30'd4};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h10, 32'h08000293, 1'b0, 30'd5};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h14, 32'h0020A223, 1'b0, 30'd6};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 32'h00, 32'h00000000, 1'b1, 30'd6};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 32'h00, 32'h00000000, 1'b1, 30'd6};
        wrap_exp[0] = 32'hFFFF_FFFC;
        wrap_exp[1] = 32'h0000_0000;
        wrap_exp[2] = 32'h0000_0004;

        // Reset values and free run to the zero-word halt
        do_reset();
        chk("rst_valid", dec_valid, 0);
        chk("rst_pc", dec_pc, 0);
        chk("rst_instr", dec_instr, 0);
        chk("rst_halted", halted, 0);
        chk("rst_mis", misalign, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_addr", imem_addr, 0);
        for (int k = 0; k < 8; k++) begin
            fetch_en  = tbl[k].fe;
            dec_ready = tbl[k].rdy;
            cyc();
            chk("run_valid", dec_valid, tbl[k].exp_valid);
            chk("run_halted", halted, tbl[k].exp_halted);
            chk("run_addr", imem_addr, tbl[k].exp_addr);
            if (tbl[k].exp_valid) begin
                chk("run_pc", dec_pc, tbl[k].exp_pc);
                chk("run_instr", dec_instr, tbl[k].exp_instr);
            end
            if (k < 3) begin
                chk("wrap_pc", w_pc, wrap_exp[k]);
                chk("wrap_instr", w_instr, 32'h0000_0013);
            end
        end

        // Misaligned redirect out of HALTED
        dec_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0006;
        cyc();
        redirect_valid = 1'b0;
        chk("rdh_halted", halted, 0);
        chk("rdh_mis", misalign, 1);
        chk("rdh_addr", imem_addr, 1);
        chk("rdh_count", fifo_count, 0);
        cyc();
        chk("rdh_mis_pulse", misalign, 0);
        chk("rdh_valid", dec_valid, 1);
        chk("rdh_pc", dec_pc, 32'h4);
        chk("rdh_instr", dec_instr, 32'h00108133);

        // Backpressure from reset, then release
        do_reset();
        fetch_en = 1'b1;
        repeat (3) cyc();
        chk("bp_count", fifo_count, 2);
        chk("bp_addr", imem_addr, 2);
        dec_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_pc", dec_pc, 32'(i * 4));
            chk("bp_instr", dec_instr, prog[i]);
            cyc();
            if (i == 0) chk("bp_full_pop_count", fifo_count, 2);
        end

        // Redirect while full
        do_reset();
        fetch_en = 1'b1;
        repeat (3) cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8;
        cyc();
        redirect_valid = 1'b0;
        chk("rdf_count", fifo_count, 0);
        chk("rdf_valid", dec_valid, 0);
        chk("rdf_addr", imem_addr, 2);
        chk("rdf_mis", misalign, 0);
        cyc();
        chk("rdf_pc", dec_pc, 32'h8);
        chk("rdf_instr", dec_instr, 32'h001081B3);

        // Asynchronous reset between edges
        do_reset();
        fetch_en  = 1'b1;
        dec_ready = 1'b1;
        repeat (3) cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", dec_valid, 0);
        chk("arst_count", fifo_count, 0);
        chk("arst_addr", imem_addr, 0);
        chk("arst_pc", dec_pc, 0);
        chk("arst_instr", dec_instr, 0);
        chk("arst_halted", halted, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("arst_first_pc", dec_pc, 32'h0);
        chk("arst_first_valid", dec_valid, 1);

        // Randomized run against the queue model
        do_reset();
        m_q.delete();
        m_pc     = 32'h0;
        m_halted = 1'b0;
        m_mis    = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            logic        pop;
            logic        slot;
            logic [31:0] word;
            fetch_en       = ($urandom_range(0, 9) != 0);
            dec_ready      = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = 32'($urandom_range(0, 40));
            pop  = (m_q.size() > 0) && dec_ready;
            slot = fetch_en && !m_halted && (m_q.size() < 2 || pop);
            if (redirect_valid) begin
                m_q.delete();
                m_pc     = redirect_pc & 32'hFFFF_FFFC;
                m_halted = 1'b0;
                m_mis    = (redirect_pc % 4) != 0;
            end else begin
                m_mis = 1'b0;
                if (pop) void'(m_q.pop_front());
                if (slot) begin
                    word = imem_word(m_pc[31:2]);
                    if (word == 32'h0) begin
                        m_halted = 1'b1;
                    end else begin
                        m_q.push_back('{pc: m_pc, instr: word});
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
            cyc();
            chk("rnd_valid", dec_valid, (m_q.size() != 0));
            chk("rnd_count", fifo_count, m_q.size());
            chk("rnd_addr", imem_addr, m_pc[31:2]);
            chk("rnd_halted", halted, m_halted);
            chk("rnd_mis", misalign, m_mis);
            if (m_q.size() != 0) begin
                chk("rnd_pc", dec_pc, m_q[0].pc);
                chk("rnd_instr", dec_instr, m_q[0].instr);
            end
        end
        redirect_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
